sprite_pixel_fetch: RTL
=======================

Name: sprite_pixel_fetch

Overview:
- Downstream consumer of the sprite memory. Takes a pixel request (sprite offset plus in-sprite x/y) from the draw pipeline.
- Computes the linear memory address and drives the sprite memory's address and edge-triggered read strobe with correct setup timing.
- Captures the returned colour word and presents it with a one-cycle valid pulse and a transparency flag.
- Sits between the sprite drawing/compositing logic and the sprite memory block.

Parameters:
- ADDR_WIDTH, 14, sprite memory address width.
- DATA_WIDTH, 9, colour word width (RGB 3-3-3).
- OFFSET_WIDTH, 5, sprite offset (index) width, so 32 sprites.
- SPRITE_SIZE, 20, sprite side in pixels; each sprite is SPRITE_SIZE*SPRITE_SIZE words.
- COORD_WIDTH, 5, width of the x/y coordinate inputs.
- TRANSPARENT, 9'h1FF, colour value treated as transparent.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  request strobe; sampled only while idle.
- i_offset  in  OFFSET_WIDTH  sprite index.
- i_x  in  COORD_WIDTH  column within the sprite.
- i_y  in  COORD_WIDTH  row within the sprite.
- o_busy  out  1  high while a request is in flight.
- o_mem_addr  out  ADDR_WIDTH  address to sprite memory.
- o_mem_read  out  1  read strobe to sprite memory; memory samples on its rising edge.
- i_mem_data  in  DATA_WIDTH  data from sprite memory.
- o_pixel  out  DATA_WIDTH  fetched colour.
- o_valid  out  1  one-cycle pulse; o_pixel and o_transparent are valid.
- o_transparent  out  1  high when o_pixel equals TRANSPARENT or coordinates were out of range.
- o_range_err  out  1  one-cycle pulse alongside o_valid when i_x or i_y >= SPRITE_SIZE.

Behaviour:
- Reset: asynchronous on i_rst_n low. Clock and reset are as listed above; synchronicity and polarity are fixed.
  - State goes to IDLE.
  - o_busy, o_mem_read, o_valid, o_transparent and o_range_err go to 0.
  - o_mem_addr and o_pixel go to 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, CAPTURE.
- IDLE:
  - If i_req=1 and the coordinates are in range: latch the inputs, register o_mem_addr = i_offset*SPRITE_SIZE*SPRITE_SIZE + i_y*SPRITE_SIZE + i_x, then go to SETUP.
  - If i_req=1 and the coordinates are out of range: no memory access. Next cycle output o_valid=1, o_range_err=1, o_transparent=1, o_pixel=TRANSPARENT. Stay in IDLE.
- SETUP: o_mem_read=0, address stable for one full cycle. Go to STROBE.
- STROBE: o_mem_read=1; the memory updates its output on that rising edge. Go to CAPTURE.
- CAPTURE:
  - o_mem_read stays 1.
  - Register o_pixel=i_mem_data, o_valid=1, o_transparent=(i_mem_data==TRANSPARENT).
  - Go to IDLE; o_mem_read returns to 0 on that transition.
- Latency: request accepted at edge t, so o_valid is high during the cycle after edge t+3. One request per 4 cycles at maximum rate; a new request may be accepted in the cycle o_valid is high.
- o_busy = (state != IDLE).
- i_req while busy is ignored. No queuing; the requester must wait for o_busy=0.
- Arithmetic: compute the address at full precision of (OFFSET_WIDTH + 2*COORD_WIDTH + 2) bits, then truncate to ADDR_WIDTH. Constant multiplies only (no variable multiplier). Maximum address with defaults = 31*400 + 399 = 12799 < 2^14.
- Boundary x = y = SPRITE_SIZE-1 is in range. x or y = SPRITE_SIZE is a range error.
- Reset mid-fetch: o_mem_read drops to 0 immediately and no o_valid is produced.
- o_valid, o_range_err and o_transparent are single-cycle pulses. o_pixel holds its last value.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, SETUP=1, STROBE=2, CAPTURE=3).
  - Default sprite geometry constants (SPRITE_SIZE, SPRITE_WORDS=400).
  - The TRANSPARENT colour constant.
- One natural sub-module: sprite_addr_calc, purely combinational, mapping offset/x/y to the address plus a range-error flag.

Test Plan:
- Reset with i_rst_n=0 mid-STROBE -> o_mem_read=0, o_busy=0, o_valid=0 asynchronously; no valid afterward.
- i_req, offset=2, x=3, y=1, memory word 0x0A5 -> o_mem_addr=823, one low cycle then o_mem_read high; o_valid with o_pixel=0x0A5 and o_transparent=0, valid high during the cycle after edge t+3.
- offset=31, x=19, y=19, word 0x1FF -> address 12799; o_valid with o_transparent=1.
- i_x=20, i_y=0 -> no o_mem_read pulse; next cycle o_valid=1, o_range_err=1, o_pixel=0x1FF.
- i_req held high for 12 cycles -> exactly 3 fetches, back-to-back spacing of 4 cycles, requests during busy ignored.
- Scoreboard: 200 random in-range requests against the memory model -> every o_pixel matches the expected word, address within 0..12799.

Source files
------------

// File: rtl/sprite_pixel_fetch_pkg.sv
// sprite_pixel_fetch_pkg: shared FSM encoding, sprite geometry and colour constants
package sprite_pixel_fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, CAPTURE = 2'd3} state_t;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 9;
  localparam int DEF_SPRITE_SIZE = 20;
  localparam int SPRITE_WORDS = DEF_SPRITE_SIZE * DEF_SPRITE_SIZE;
  localparam logic [8:0] DEF_TRANSPARENT = 9'h1FF;
endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// sprite_pixel_fetch_if: sprite memory bus (address, edge-triggered read strobe, data)
interface sprite_pixel_fetch_if
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_read;
  logic [DATA_WIDTH-1:0] i_mem_data;
  modport master (output o_mem_addr, output o_mem_read, input i_mem_data);
  modport slave (input o_mem_addr, input o_mem_read, output i_mem_data);
endinterface

// File: rtl/sprite_pixel_fetch_addr_calc.sv
// sprite_addr_calc: maps sprite offset/x/y to a linear memory address plus a range-error flag
module sprite_addr_calc #(
  parameter int ADDR_WIDTH   = 14,
  parameter int OFFSET_WIDTH = 5,
  parameter int COORD_WIDTH  = 5,
  parameter int SPRITE_SIZE  = 20
) (
  input  logic [OFFSET_WIDTH-1:0] i_offset,
  input  logic [COORD_WIDTH-1:0]  i_x,
  input  logic [COORD_WIDTH-1:0]  i_y,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic                    o_range_err
);
  localparam int FW = OFFSET_WIDTH + 2 * COORD_WIDTH + 2;
  assign o_addr = ADDR_WIDTH'(FW'(i_offset) * FW'(SPRITE_SIZE * SPRITE_SIZE)
                + FW'(i_y) * FW'(SPRITE_SIZE) + FW'(i_x));
  assign o_range_err = (int'(i_x) >= SPRITE_SIZE) || (int'(i_y) >= SPRITE_SIZE);
endmodule

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: fetches one sprite pixel per request via a setup/strobe/capture read sequence
module sprite_pixel_fetch
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int OFFSET_WIDTH = 5,
  parameter int SPRITE_SIZE  = DEF_SPRITE_SIZE,
  parameter int COORD_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = DATA_WIDTH'(DEF_TRANSPARENT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req,
  input  logic [OFFSET_WIDTH-1:0] i_offset,
  input  logic [COORD_WIDTH-1:0]  i_x,
  input  logic [COORD_WIDTH-1:0]  i_y,
  output logic                    o_busy,
  sprite_pixel_fetch_if.master    mem,
  output logic [DATA_WIDTH-1:0]   o_pixel,
  output logic                    o_valid,
  output logic                    o_transparent,
  output logic                    o_range_err
);
  state_t                r_state;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_read;
  logic [DATA_WIDTH-1:0] r_pixel;
  logic                  r_valid;
  logic                  r_transparent;
  logic                  r_range_err;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_range_err;
  sprite_addr_calc #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .COORD_WIDTH (COORD_WIDTH),
    .SPRITE_SIZE (SPRITE_SIZE)
  ) u_addr_calc (
    .i_offset   (i_offset),
    .i_x        (i_x),
    .i_y        (i_y),
    .o_addr     (w_addr),
    .o_range_err(w_range_err)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_addr        <= '0;
      r_read        <= 1'b0;
      r_pixel       <= '0;
      r_valid       <= 1'b0;
      r_transparent <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      r_valid       <= 1'b0;
      r_transparent <= 1'b0;
      r_range_err   <= 1'b0;
      case (r_state)
        IDLE: if (i_req) begin
          if (w_range_err) begin
            r_valid       <= 1'b1;
            r_transparent <= 1'b1;
            r_range_err   <= 1'b1;
            r_pixel       <= TRANSPARENT;
          end else begin
            r_addr  <= w_addr;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_read  <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: r_state <= CAPTURE;
        CAPTURE: begin
          r_pixel       <= mem.i_mem_data;
          r_valid       <= 1'b1;
          r_transparent <= mem.i_mem_data == TRANSPARENT;
          r_read        <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_busy         = r_busy;
  assign mem.o_mem_addr = r_addr;
  assign mem.o_mem_read = r_read;
  assign o_pixel        = r_pixel;
  assign o_valid        = r_valid;
  assign o_transparent  = r_transparent;
  assign o_range_err    = r_range_err;
endmodule
